// File: rtl/sdram_device_model.sv
// Behavioural SDR SDRAM device: four banks, mode register, CAS-latency read pipe,
// wrapped bursts and sticky detection of protocol/timing violations.
module sdram_device_model #(
  parameter int unsigned CL_DEFAULT = 2,
  parameter int unsigned T_RCD      = 3,
  parameter int unsigned T_RP       = 3,
  parameter int unsigned T_RFC      = 7,
  parameter int unsigned ROW_BITS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_cle,
  input  logic        sdram_cs,
  input  logic        sdram_ras,
  input  logic        sdram_cas,
  input  logic        sdram_we,
  input  logic        sdram_dqm,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic [31:0] sdram_dqo,
  output logic [31:0] sdram_dqi,
  output logic        dq_oe,
  output logic        protocol_err,
  output logic [2:0]  err_code
);

  localparam int unsigned AW = 2 + ROW_BITS + 8;
  localparam int unsigned TW = 8;

  typedef enum logic [2:0] {
    CmdNop, CmdActive, CmdRead, CmdWrite, CmdBst, CmdPre, CmdRef, CmdMode
  } cmd_e;
  typedef enum logic [1:0] {BurstIdle, BurstRead, BurstWrite} burst_e;

  logic [31:0] mem [2**AW];

  cmd_e                cmd;
  logic [3:0]          open_q, open_d;
  logic [ROW_BITS-1:0] row_q [4];
  logic [ROW_BITS-1:0] row_d [4];
  logic [TW-1:0]       rcd_q [4];
  logic [TW-1:0]       rcd_d [4];
  logic [TW-1:0]       rp_q, rp_d, rfc_q, rfc_d;
  logic [2:0]          cl_q, cl_d, bl_mask_q, bl_mask_d;
  burst_e              burst_q, burst_d;
  logic [AW-9:0]       burst_hi_q, burst_hi_d;
  logic [7:0]          burst_col_q, burst_col_d, col_next, mask8;
  logic [2:0]          burst_left_q, burst_left_d;
  logic                pipe_v_q, pipe_v_d;
  logic [31:0]         pipe_d_q, pipe_d_d, dqi_d;
  logic                dq_oe_d, perr_d;
  logic [2:0]          code_d, new_code;
  logic                is_rw, bank_open, mode_bad;
  logic                rd_issue, wr_en;
  logic [AW-1:0]       rd_addr, wr_addr;
  logic [31:0]         rd_data;
  logic                unused_a;

  assign unused_a = ^sdram_a[12:11];

  always_comb begin
    cmd = CmdNop;
    if (!sdram_cs) begin
      case ({sdram_ras, sdram_cas, sdram_we})
        3'b011:  cmd = CmdActive;
        3'b101:  cmd = CmdRead;
        3'b100:  cmd = CmdWrite;
        3'b110:  cmd = CmdBst;
        3'b010:  cmd = CmdPre;
        3'b001:  cmd = CmdRef;
        3'b000:  cmd = CmdMode;
        default: cmd = CmdNop;
      endcase
    end
  end

  // Later assignments override earlier ones, so the lowest code wins.
  always_comb begin
    is_rw     = (cmd == CmdRead) || (cmd == CmdWrite);
    bank_open = open_q[sdram_ba];
    mode_bad  = (sdram_a[2:0] > 3'd3) || (sdram_a[6:4] < 3'd2) || (sdram_a[6:4] > 3'd3);
    new_code  = 3'd0;
    if (cmd == CmdMode && mode_bad) new_code = 3'd5;
    if ((cmd != CmdNop && rfc_q != '0) ||
        ((cmd == CmdActive || cmd == CmdRef) && rp_q != '0) ||
        (cmd == CmdRef && |open_q)) new_code = 3'd4;
    if (is_rw && bank_open && rcd_q[sdram_ba] != '0) new_code = 3'd3;
    if (cmd == CmdActive && bank_open) new_code = 3'd2;
    if (is_rw && !bank_open) new_code = 3'd1;
  end

  always_comb begin
    open_d       = open_q;
    row_d        = row_q;
    rcd_d        = rcd_q;
    rp_d         = (rp_q != '0) ? rp_q - TW'(1) : rp_q;
    rfc_d        = (rfc_q != '0) ? rfc_q - TW'(1) : rfc_q;
    cl_d         = cl_q;
    bl_mask_d    = bl_mask_q;
    burst_d      = burst_q;
    burst_hi_d   = burst_hi_q;
    burst_col_d  = burst_col_q;
    burst_left_d = burst_left_q;
    rd_issue     = 1'b0;
    wr_en        = 1'b0;
    rd_addr      = {burst_hi_q, burst_col_q};
    wr_addr      = {burst_hi_q, burst_col_q};
    mask8        = {5'b0, bl_mask_q};
    col_next     = (burst_col_q & ~mask8) | ((burst_col_q + 8'd1) & mask8);
    for (int b = 0; b < 4; b++) begin
      if (rcd_q[b] != '0) rcd_d[b] = rcd_q[b] - TW'(1);
    end

    unique case (cmd)
      CmdActive: begin
        open_d[sdram_ba] = 1'b1;
        row_d[sdram_ba]  = sdram_a[ROW_BITS-1:0];
        rcd_d[sdram_ba]  = TW'(T_RCD - 1);
      end
      CmdPre: begin
        if (sdram_a[10]) open_d = '0;
        else             open_d[sdram_ba] = 1'b0;
        rp_d = TW'(T_RP - 1);
      end
      CmdRef: rfc_d = TW'(T_RFC - 1);
      CmdMode: begin
        if (!mode_bad) begin
          cl_d = sdram_a[6:4];
          case (sdram_a[1:0])
            2'd0:    bl_mask_d = 3'd0;
            2'd1:    bl_mask_d = 3'd1;
            2'd2:    bl_mask_d = 3'd3;
            default: bl_mask_d = 3'd7;
          endcase
        end
      end
      default: ;
    endcase

    // Any column command or terminate ends a running burst at this edge.
    if (burst_q != BurstIdle) begin
      if (is_rw || cmd == CmdPre || cmd == CmdBst) begin
        burst_d = BurstIdle;
      end else begin
        burst_col_d  = col_next;
        burst_left_d = burst_left_q - 3'd1;
        rd_addr      = {burst_hi_q, col_next};
        wr_addr      = {burst_hi_q, col_next};
        rd_issue     = (burst_q == BurstRead);
        wr_en        = (burst_q == BurstWrite) && !sdram_dqm;
        if (burst_left_q == 3'd1) burst_d = BurstIdle;
      end
    end

    if (is_rw && new_code == 3'd0) begin
      burst_hi_d   = {sdram_ba, row_q[sdram_ba]};
      burst_col_d  = sdram_a[9:2];
      burst_left_d = bl_mask_q;
      rd_addr      = {sdram_ba, row_q[sdram_ba], sdram_a[9:2]};
      wr_addr      = rd_addr;
      rd_issue     = (cmd == CmdRead);
      wr_en        = (cmd == CmdWrite) && !sdram_dqm;
      if (bl_mask_q == 3'd0)      burst_d = BurstIdle;
      else if (cmd == CmdRead)    burst_d = BurstRead;
      else                        burst_d = BurstWrite;
    end
  end

  assign rd_data = mem[rd_addr];

  // CL2 drives the array word straight to the output register; CL3 adds one stage.
  always_comb begin
    pipe_v_d = rd_issue;
    pipe_d_d = rd_issue ? rd_data : '0;
    dq_oe_d  = (cl_q == 3'd2) ? rd_issue : pipe_v_q;
    dqi_d    = (cl_q == 3'd2) ? pipe_d_d : pipe_d_q;
    if (!dq_oe_d) dqi_d = '0;
    if (cmd == CmdWrite) begin
      pipe_v_d = 1'b0;
      dq_oe_d  = 1'b0;
      dqi_d    = '0;
    end
    perr_d = protocol_err;
    code_d = err_code;
    if (!protocol_err && new_code != 3'd0) begin
      perr_d = 1'b1;
      code_d = new_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q       <= '0;
      row_q        <= '{default: '0};
      rcd_q        <= '{default: '0};
      rp_q         <= '0;
      rfc_q        <= '0;
      cl_q         <= 3'(CL_DEFAULT);
      bl_mask_q    <= 3'd0;
      burst_q      <= BurstIdle;
      burst_hi_q   <= '0;
      burst_col_q  <= '0;
      burst_left_q <= '0;
      pipe_v_q     <= 1'b0;
      pipe_d_q     <= '0;
      sdram_dqi    <= '0;
      dq_oe        <= 1'b0;
      protocol_err <= 1'b0;
      err_code     <= 3'd0;
    end else if (sdram_cle) begin
      open_q       <= open_d;
      row_q        <= row_d;
      rcd_q        <= rcd_d;
      rp_q         <= rp_d;
      rfc_q        <= rfc_d;
      cl_q         <= cl_d;
      bl_mask_q    <= bl_mask_d;
      burst_q      <= burst_d;
      burst_hi_q   <= burst_hi_d;
      burst_col_q  <= burst_col_d;
      burst_left_q <= burst_left_d;
      pipe_v_q     <= pipe_v_d;
      pipe_d_q     <= pipe_d_d;
      sdram_dqi    <= dqi_d;
      dq_oe        <= dq_oe_d;
      protocol_err <= perr_d;
      err_code     <= code_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!rst && sdram_cle && wr_en) mem[wr_addr] <= sdram_dqo;
  end

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: a vector table for the main data paths plus
// hand sequences for reset, latency, clock-enable and violation corner cases.
module tb_sdram_device_model;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] BST = 4'b0110;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cle = 1'b1;
  logic        cs, ras, cas, we, dqm;
  logic [1:0]  ba;
  logic [12:0] a;
  logic [31:0] dqo, dqi;
  logic        oe, perr;
  logic [2:0]  code;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  sdram_device_model dut (
    .clk          (clk),
    .rst          (rst),
    .sdram_cle    (cle),
    .sdram_cs     (cs),
    .sdram_ras    (ras),
    .sdram_cas    (cas),
    .sdram_we     (we),
    .sdram_dqm    (dqm),
    .sdram_ba     (ba),
    .sdram_a      (a),
    .sdram_dqo    (dqo),
    .sdram_dqi    (dqi),
    .dq_oe        (oe),
    .protocol_err (perr),
    .err_code     (code)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [31:0] dqo;
    logic        dqm;
    logic        chk;
    logic [31:0] dqi;
    logic        oe;
    logic        perr;
    logic [2:0]  code;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad,
                     input logic [31:0] d, input logic m, input logic k,
                     input logic [31:0] edq, input logic eoe, input logic eperr,
                     input logic [2:0] ecode);
    vec_t v;
    v.cmd = c; v.ba = b; v.a = ad; v.dqo = d; v.dqm = m; v.chk = k;
    v.dqi = edq; v.oe = eoe; v.perr = eperr; v.code = ecode;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, exp);
  endtask

  task automatic check_all(input string name, input logic [31:0] edq, input logic eoe,
                           input logic eperr, input logic [2:0] ecode);
    check({name, " dqi"}, dqi, edq);
    check({name, " dq_oe"}, {31'b0, oe}, {31'b0, eoe});
    check({name, " protocol_err"}, {31'b0, perr}, {31'b0, eperr});
    check({name, " err_code"}, {29'b0, code}, {29'b0, ecode});
  endtask

  // Drive one command, let one rising edge pass, then settle past it.
  task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad,
                      input logic [31:0] d, input logic m);
    {cs, ras, cas, we} = c;
    ba = b; a = ad; dqo = d; dqm = m;
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic m);
    step(NOP, 2'd0, 13'h0, 32'h0, m);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    // Defaults after reset: CL2, BL1.
    add(ACT, 2'd1, 13'h005, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(WR,  2'd1, 13'h020, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(RD,  2'd1, 13'h020, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 3'd0);
    // CL2 BL4: write col 6 wraps to 4,5; read col 4 returns 3,4,1,2.
    add(MRS, 2'd0, 13'h022, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 3'd0);
    add(WR,  2'd1, 13'h018, 32'h1,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h2,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h3,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h4,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 3'd0);
    add(RD,  2'd1, 13'h010, 32'h0,        1'b0, 1'b1, 32'h3,        1'b1, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b1, 32'h4,        1'b1, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b1, 32'h1,        1'b1, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b1, 32'h2,        1'b1, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 3'd0);
    // Burst terminate cuts a BL4 read after two words.
    add(RD,  2'd1, 13'h010, 32'h0,        1'b0, 1'b1, 32'h3,        1'b1, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b1, 32'h4,        1'b1, 1'b0, 3'd0);
    add(BST, 2'd0, 13'h000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 3'd0);
    // Back to BL1; masked write leaves the earlier word.
    add(MRS, 2'd0, 13'h020, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(WR,  2'd1, 13'h00C, 32'h11111111, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0);
    add(WR,  2'd1, 13'h00C, 32'h22222222, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 3'd0);
    add(RD,  2'd1, 13'h00C, 32'h0,        1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0, 3'd0);
    add(RD,  2'd1, 13'h010, 32'h0,        1'b0, 1'b1, 32'h3,        1'b1, 1'b0, 3'd0);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 3'd0);
    // Read of a never-opened bank.
    add(RD,  2'd2, 13'h000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 3'd1);
    add(NOP, 2'd0, 13'h000, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 3'd1);

    {cs, ras, cas, we} = NOP;
    ba = '0; a = '0; dqo = '0; dqm = 1'b0;
    rst = 1'b1;
    nop(1'b0);
    nop(1'b0);
    check_all("reset", 32'h0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].cmd, vecs[i].ba, vecs[i].a, vecs[i].dqo, vecs[i].dqm);
      if (vecs[i].chk)
        check_all($sformatf("vec%0d", i), vecs[i].dqi, vecs[i].oe, vecs[i].perr, vecs[i].code);
    end

    // tRCD violation, then a later ACTIVE to the open bank keeps the first code.
    do_reset();
    step(ACT, 2'd0, 13'h002, 32'h0, 1'b0);
    step(RD,  2'd0, 13'h000, 32'h0, 1'b0);
    check_all("rcd_violation", 32'h0, 1'b0, 1'b1, 3'd3);
    nop(1'b0); nop(1'b0); nop(1'b0);
    step(ACT, 2'd0, 13'h003, 32'h0, 1'b0);
    check_all("rcd_sticky", 32'h0, 1'b0, 1'b1, 3'd3);

    // tRCD boundary: READ exactly T_RCD edges after ACTIVE is legal.
    do_reset();
    step(ACT, 2'd0, 13'h000, 32'h0, 1'b0);
    nop(1'b0); nop(1'b0);
    step(RD,  2'd0, 13'h000, 32'h0, 1'b0);
    check("rcd_boundary perr", {31'b0, perr}, 32'h0);
    check("rcd_boundary oe", {31'b0, oe}, 32'h1);

    // Reset mid-burst with an error pending; memory survives reset.
    do_reset();
    step(RD,  2'd2, 13'h000, 32'h0, 1'b0);
    step(MRS, 2'd0, 13'h022, 32'h0, 1'b0);
    step(ACT, 2'd1, 13'h005, 32'h0, 1'b0);
    nop(1'b0); nop(1'b0); nop(1'b0);
    step(RD,  2'd1, 13'h010, 32'h0, 1'b0);
    check_all("rst_burst w0", 32'h3, 1'b1, 1'b1, 3'd1);
    nop(1'b0);
    check_all("rst_burst w1", 32'h4, 1'b1, 1'b1, 3'd1);
    rst = 1'b1;
    nop(1'b0);
    check_all("rst_burst reset", 32'h0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    nop(1'b0);
    check_all("rst_burst after1", 32'h0, 1'b0, 1'b0, 3'd0);
    nop(1'b0);
    check_all("rst_burst after2", 32'h0, 1'b0, 1'b0, 3'd0);
    step(RD,  2'd1, 13'h010, 32'h0, 1'b0);
    check_all("rst_banks_closed", 32'h0, 1'b0, 1'b1, 3'd1);

    // CL3: WRITE drops the pipe word; clock enable low freezes the pipe.
    do_reset();
    step(MRS, 2'd0, 13'h032, 32'h0, 1'b0);
    step(ACT, 2'd1, 13'h005, 32'h0, 1'b0);
    nop(1'b0); nop(1'b0); nop(1'b0);
    step(RD,  2'd1, 13'h010, 32'h0, 1'b0);
    check_all("cl3 edge0", 32'h0, 1'b0, 1'b0, 3'd0);
    nop(1'b0);
    check_all("cl3 edge1", 32'h3, 1'b1, 1'b0, 3'd0);
    step(WR,  2'd1, 13'h000, 32'hFFFFFFFF, 1'b1);
    check_all("cl3 write_drop", 32'h0, 1'b0, 1'b0, 3'd0);
    nop(1'b1); nop(1'b1); nop(1'b1);
    check_all("cl3 masked_wr", 32'h0, 1'b0, 1'b0, 3'd0);
    step(RD,  2'd1, 13'h010, 32'h0, 1'b0);
    cle = 1'b0;
    nop(1'b0);
    check_all("cle_freeze1", 32'h0, 1'b0, 1'b0, 3'd0);
    step(RD,  2'd2, 13'h000, 32'h0, 1'b0);
    check_all("cle_freeze2", 32'h0, 1'b0, 1'b0, 3'd0);
    cle = 1'b1;
    nop(1'b0);
    check("cle w0", dqi, 32'h3);
    nop(1'b0);
    check("cle w1", dqi, 32'h4);
    nop(1'b0);
    check("cle w2", dqi, 32'h1);
    nop(1'b0);
    check("cle w3", dqi, 32'h2);
    nop(1'b0);
    check_all("cle end", 32'h0, 1'b0, 1'b0, 3'd0);

    // tRP violation after precharge-all.
    do_reset();
    step(PRE, 2'd0, 13'h400, 32'h0, 1'b0);
    step(ACT, 2'd0, 13'h000, 32'h0, 1'b0);
    check_all("rp_violation", 32'h0, 1'b0, 1'b1, 3'd4);

    // Bad mode is flagged and leaves CL2/BL1 in place.
    do_reset();
    step(MRS, 2'd0, 13'h027, 32'h0, 1'b0);
    check_all("bad_mode", 32'h0, 1'b0, 1'b1, 3'd5);
    step(ACT, 2'd1, 13'h005, 32'h0, 1'b0);
    nop(1'b0); nop(1'b0); nop(1'b0);
    step(RD,  2'd1, 13'h010, 32'h0, 1'b0);
    check_all("bad_mode cl2", 32'h3, 1'b1, 1'b1, 3'd5);
    nop(1'b0);
    check_all("bad_mode bl1", 32'h0, 1'b0, 1'b1, 3'd5);

    // ACTIVE to open bank during tRP: both 2 and 4 apply, 2 is recorded.
    do_reset();
    step(ACT, 2'd0, 13'h000, 32'h0, 1'b0);
    step(PRE, 2'd1, 13'h000, 32'h0, 1'b0);
    check("pre_closed perr", {31'b0, perr}, 32'h0);
    step(ACT, 2'd0, 13'h001, 32'h0, 1'b0);
    check_all("simultaneous", 32'h0, 1'b0, 1'b1, 3'd2);

    // REFRESH with a bank open.
    do_reset();
    step(ACT, 2'd0, 13'h000, 32'h0, 1'b0);
    nop(1'b0);
    step(REF, 2'd0, 13'h000, 32'h0, 1'b0);
    check_all("ref_open", 32'h0, 1'b0, 1'b1, 3'd4);

    // tRFC: one edge short is a violation, exactly T_RFC edges is legal.
    do_reset();
    step(REF, 2'd0, 13'h000, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) nop(1'b0);
    step(ACT, 2'd0, 13'h000, 32'h0, 1'b0);
    check_all("rfc_violation", 32'h0, 1'b0, 1'b1, 3'd4);
    do_reset();
    step(REF, 2'd0, 13'h000, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) nop(1'b0);
    step(ACT, 2'd0, 13'h000, 32'h0, 1'b0);
    check_all("rfc_boundary", 32'h0, 1'b0, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
